gear_shift_ctrl: RTL and testbench

Sequencing controller for the 2-bit gear datapath. It takes the gear encoder's requested gear and moves the committed gear one step at a time. Each step uses a clutch request/acknowledge handshake, an ack timeout and a minimum dwell time. It sits between the combinational gear encoder and the clutch actuator interface. It is the only writer of the committed gear.

---
 rtl/gear_shift_ctrl.sv | 150 +++++++++++++++
 tb/tb_gear_shift_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gear_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gear_shift_ctrl
// Brief    : Sequences committed-gear changes one step at a time through a
//            clutch disengage/engage handshake. It enforces an ack timeout
//            and a minimum dwell after each step.
// Revision : 1.0 - initial release
// ============================================================================
module gear_shift_ctrl #(
  parameter int HOLD_CYCLES = 4,  // dwell cycles in HOLD after each step (1..15)
  parameter int ACK_TIMEOUT = 8   // cycles allowed for an ack edge (1..15)
) (
  input  logic       clk,
  input  logic       rst,          // asynchronous, active-low
  input  logic [1:0] target_gear,
  input  logic       target_valid,
  input  logic       clutch_ack,   // high = clutch disengaged
  input  logic       clear_fault,
  output logic       clutch_req,
  output logic [1:0] cur_gear,
  output logic       shifting,
  output logic       fault
);

  // Terminal counts for the 4-bit phase counter.
  localparam logic [3:0] TIMEOUT_LAST = 4'(ACK_TIMEOUT - 1);
  localparam logic [3:0] HOLD_LAST    = 4'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CLUTCH_OUT = 3'd1,
    ST_SHIFT      = 3'd2,
    ST_CLUTCH_IN  = 3'd3,
    ST_HOLD       = 3'd4,
    ST_FAULT      = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       dir;          // 1 = step up, 0 = step down
  logic       dir_nxt;
  logic [1:0] gear_nxt;
  logic       req_nxt;
  logic       shifting_nxt;
  logic       fault_nxt;

  // State, counter, direction, committed gear and output flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      dir        <= 1'b0;
      cur_gear   <= 2'd0;
      clutch_req <= 1'b0;
      shifting   <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dir        <= dir_nxt;
      cur_gear   <= gear_nxt;
      clutch_req <= req_nxt;
      shifting   <= shifting_nxt;
      fault      <= fault_nxt;
    end
  end

  // Next-state, counter and gear logic. The outputs are decoded from the
  // next state so that they line up with the state register.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 4'd1;
    dir_nxt   = dir;
    gear_nxt  = cur_gear;

    case (state)
      ST_IDLE: begin
        // Only IDLE looks at the target. A multi-gear request is served
        // as repeated single steps, one pass through IDLE for each step.
        cnt_nxt = 4'd0;
        if (target_valid && (target_gear != cur_gear)) begin
          dir_nxt   = (target_gear > cur_gear);
          state_nxt = ST_CLUTCH_OUT;
        end
      end

      ST_CLUTCH_OUT: begin
        // Ack wins over a timeout that expires in the same cycle.
        if (clutch_ack) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = 4'd0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = ST_FAULT;
          cnt_nxt   = 4'd0;
        end
      end

      ST_SHIFT: begin
        // Direction came from an unsigned compare with the target, so the
        // step can never carry the gear past 3 or below 0.
        if (dir) begin
          gear_nxt = cur_gear + 2'd1;
        end else begin
          gear_nxt = cur_gear - 2'd1;
        end
        state_nxt = ST_CLUTCH_IN;
        cnt_nxt   = 4'd0;
      end

      ST_CLUTCH_IN: begin
        if (!clutch_ack) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = 4'd0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = ST_FAULT;
          cnt_nxt   = 4'd0;
        end
      end

      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 4'd0;
        end
      end

      ST_FAULT: begin
        // Gear stays frozen. Only an explicit clear leaves this state.
        cnt_nxt = 4'd0;
        if (clear_fault) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase

    req_nxt      = (state_nxt == ST_CLUTCH_OUT) || (state_nxt == ST_SHIFT);
    shifting_nxt = (state_nxt == ST_CLUTCH_OUT) || (state_nxt == ST_SHIFT) ||
                   (state_nxt == ST_CLUTCH_IN)  || (state_nxt == ST_HOLD);
    fault_nxt    = (state_nxt == ST_FAULT);
  end

endmodule
`default_nettype wire

// File: tb/tb_gear_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gear_shift_ctrl
// Brief    : Self-checking bench for gear_shift_ctrl. A phase-level reference
//            model is compared against the DUT every cycle. Directed scenarios
//            add hand-computed literal expectations, followed by a random run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gear_shift_ctrl;

  localparam int HOLD_CYCLES = 4;
  localparam int ACK_TIMEOUT = 8;

  logic       clk;
  logic       rst;
  logic [1:0] target_gear;
  logic       target_valid;
  logic       clutch_ack;
  logic       clear_fault;
  logic       clutch_req;
  logic [1:0] cur_gear;
  logic       shifting;
  logic       fault;

  gear_shift_ctrl #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .target_gear  (target_gear),
    .target_valid (target_valid),
    .clutch_ack   (clutch_ack),
    .clear_fault  (clear_fault),
    .clutch_req   (clutch_req),
    .cur_gear     (cur_gear),
    .shifting     (shifting),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. It tracks which phase of a single-step gear change we are
  // in and how many cycles were already spent there. Gear is a plain integer.
  // --------------------------------------------------------------------------
  localparam int PH_IDLE  = 0;  // waiting for a differing target
  localparam int PH_OPEN  = 1;  // asking for disengage, waiting for ack high
  localparam int PH_MOVE  = 2;  // one cycle: gear moves at its end
  localparam int PH_CLOSE = 3;  // asking for engage, waiting for ack low
  localparam int PH_DWELL = 4;  // post-step dwell
  localparam int PH_FAULT = 5;

  int m_phase = PH_IDLE;
  int m_spent = 0;
  int m_gear  = 0;
  int m_up    = 0;

  // Advance the model on every clock edge, using the inputs seen at that edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= PH_IDLE;
      m_spent <= 0;
      m_gear  <= 0;
      m_up    <= 0;
    end else begin
      m_spent <= m_spent + 1;
      case (m_phase)
        PH_IDLE: begin
          m_spent <= 0;
          if (target_valid && int'(target_gear) != m_gear) begin
            m_up    <= (int'(target_gear) > m_gear) ? 1 : 0;
            m_phase <= PH_OPEN;
          end
        end
        PH_OPEN: begin
          if (clutch_ack) begin
            m_phase <= PH_MOVE; m_spent <= 0;
          end else if (m_spent + 1 >= ACK_TIMEOUT) begin
            m_phase <= PH_FAULT; m_spent <= 0;
          end
        end
        PH_MOVE: begin
          m_gear  <= m_up ? m_gear + 1 : m_gear - 1;
          m_phase <= PH_CLOSE; m_spent <= 0;
        end
        PH_CLOSE: begin
          if (!clutch_ack) begin
            m_phase <= PH_DWELL; m_spent <= 0;
          end else if (m_spent + 1 >= ACK_TIMEOUT) begin
            m_phase <= PH_FAULT; m_spent <= 0;
          end
        end
        PH_DWELL: begin
          if (m_spent + 1 >= HOLD_CYCLES) begin
            m_phase <= PH_IDLE; m_spent <= 0;
          end
        end
        default: begin
          m_spent <= 0;
          if (clear_fault) m_phase <= PH_IDLE;
        end
      endcase
    end
  end

  // Compare the DUT with the model on each falling edge. Also require every
  // gear change outside reset to be a single step.
  int  prev_gear = 0;
  bit  prev_rst  = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cur_gear",   int'(cur_gear), m_gear);
      check("clutch_req", int'(clutch_req), (m_phase == PH_OPEN || m_phase == PH_MOVE) ? 1 : 0);
      check("shifting",   int'(shifting),
            (m_phase == PH_OPEN || m_phase == PH_MOVE ||
             m_phase == PH_CLOSE || m_phase == PH_DWELL) ? 1 : 0);
      check("fault",      int'(fault), (m_phase == PH_FAULT) ? 1 : 0);
      if (rst && prev_rst && int'(cur_gear) != prev_gear) begin
        check("step_size", (int'(cur_gear) > prev_gear) ? int'(cur_gear) - prev_gear
                                                        : prev_gear - int'(cur_gear), 1);
      end
    end
    prev_gear = int'(cur_gear);
    prev_rst  = rst;
  end

  // --------------------------------------------------------------------------
  // Clutch actuator stand-in. It raises ack rise_delay cycles after it sees a
  // request, and drops it fall_delay cycles after the request is removed.
  // --------------------------------------------------------------------------
  int rise_delay = 0;
  int fall_delay = 0;
  initial begin
    int w;
    w = 0;
    clutch_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        clutch_ack = 1'b0; w = 0;
      end else if (clutch_req && !clutch_ack) begin
        if (w >= rise_delay) begin clutch_ack = 1'b1; w = 0; end
        else w++;
      end else if (!clutch_req && clutch_ack) begin
        if (w >= fall_delay) begin clutch_ack = 1'b0; w = 0; end
        else w++;
      end else begin
        w = 0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  int gear_log[$];
  int w_req_hi, w_rises, w_sh_hi, w_fault_hi, w_min_gap;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    tick();
    rst = 1'b0; target_gear = 2'd0;
    tick();
    rst = 1'b1;
  endtask

  // Observe ncyc falling edges. Record gear changes and request/shift activity.
  task automatic watch(input int ncyc);
    int last, prev_req, gap;
    bit fell;
    gear_log.delete();
    w_req_hi = 0; w_rises = 0; w_sh_hi = 0; w_fault_hi = 0; w_min_gap = 1000;
    last = int'(cur_gear); prev_req = int'(clutch_req); gap = 0; fell = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (int'(cur_gear) != last) begin
        gear_log.push_back(int'(cur_gear));
        last = int'(cur_gear);
      end
      if (clutch_req) w_req_hi++;
      if (shifting)   w_sh_hi++;
      if (fault)      w_fault_hi++;
      if (clutch_req && prev_req == 0) begin
        w_rises++;
        if (fell && gap < w_min_gap) w_min_gap = gap;
      end
      if (!clutch_req) gap++;
      if (!clutch_req && prev_req == 1) begin fell = 1'b1; gap = 1; end
      prev_req = int'(clutch_req);
    end
  endtask

  task automatic wait_req(input int maxc, input string nm);
    int found;
    found = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (clutch_req) begin found = 1; break; end
    end
    check(nm, found, 1);
  endtask

  task automatic check_log(input string nm, input int e0, input int e1, input int e2, input int n);
    int exp_v[3];
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2;
    check({nm, "_len"}, gear_log.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < gear_log.size()) check({nm, "_seq"}, gear_log[i], exp_v[i]);
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int cnt, found;
    rst = 1'b0; target_gear = 2'd0; target_valid = 1'b0; clear_fault = 1'b0;

    // Reset held low with random inputs.
    for (int i = 0; i < 6; i++) begin
      tick();
      cmp_en       = 1'b1;
      target_gear  = 2'($urandom);
      target_valid = 1'($urandom);
      clear_fault  = 1'($urandom);
    end
    @(negedge clk);
    check("rst_clutch_req", int'(clutch_req), 0);
    check("rst_cur_gear",   int'(cur_gear), 0);
    check("rst_shifting",   int'(shifting), 0);
    check("rst_fault",      int'(fault), 0);

    // Matching target after release: no activity.
    tick();
    rst = 1'b1; target_gear = 2'd0; target_valid = 1'b1; clear_fault = 1'b0;
    watch(20);
    check("same_target_req", w_req_hi, 0);

    // Single upshift with ack 2 cycles after request and drop 1 cycle after.
    rise_delay = 2; fall_delay = 1;
    tick();
    target_gear = 2'd1;
    @(negedge clk);
    check("up_still_idle", int'(clutch_req), 0);
    @(negedge clk);
    check("up_req_rise", int'(clutch_req), 1);
    watch(29);
    check("up_req_cycles", w_req_hi + 1, 4);
    check("up_shift_cycles", w_sh_hi + 1, 10);
    check_log("up", 1, 0, 0, 1);
    check("up_end_shifting", int'(shifting), 0);

    // Multi-step 0 -> 3 and back, immediate acks.
    reset_pulse();
    rise_delay = 0; fall_delay = 0;
    tick();
    target_gear = 2'd3;
    watch(60);
    check("multi_up_pulses", w_rises, 3);
    check_log("multi_up", 1, 2, 3, 3);
    check("multi_up_gap", (w_min_gap >= HOLD_CYCLES) ? 1 : 0, 1);
    tick();
    target_gear = 2'd0;
    watch(60);
    check_log("multi_down", 2, 1, 0, 3);

    // Ack never comes: timeout into FAULT, then clear and retry.
    rise_delay = 100;
    tick();
    target_gear = 2'd2;
    wait_req(5, "to_req_start");
    cnt = 1; found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fault) begin found = 1; break; end
      if (clutch_req) cnt++;
    end
    check("to_fault_seen", found, 1);
    check("to_req_cycles", cnt, ACK_TIMEOUT);
    check("to_req_low", int'(clutch_req), 0);
    check("to_gear_held", int'(cur_gear), 0);
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    check("to_fault_sticky", int'(fault), 1);
    rise_delay = 0;
    tick();
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    @(negedge clk);
    check("clr_fault_low", int'(fault), 0);
    check("clr_idle_req", int'(clutch_req), 0);
    @(negedge clk);
    check("clr_retry_req", int'(clutch_req), 1);
    watch(40);
    check("retry_gear", int'(cur_gear), 2);

    // Target change during CLUTCH_OUT: step to 1 finishes, then back to 0.
    reset_pulse();
    rise_delay = 3; fall_delay = 0;
    tick();
    target_gear = 2'd2;
    wait_req(5, "mid_req_start");
    tick();
    target_gear = 2'd0;
    watch(60);
    check_log("mid_change", 1, 0, 0, 2);

    // Reset pulse in SHIFT: no partial gear update.
    rise_delay = 0;
    tick();
    target_gear = 2'd1;
    wait_req(5, "rs_req_start");
    @(posedge clk);
    #1;
    check("rs_in_shift_req", int'(clutch_req), 1);
    rst = 1'b0; target_gear = 2'd0;
    #1;
    check("rs_async_req",   int'(clutch_req), 0);
    check("rs_async_shift", int'(shifting), 0);
    check("rs_async_gear",  int'(cur_gear), 0);
    tick();
    rst = 1'b1;
    watch(10);
    check("rs_no_step", gear_log.size(), 0);

    // Ack arrives in the very last allowed cycle: shift wins over timeout.
    rise_delay = ACK_TIMEOUT - 1; fall_delay = 0;
    tick();
    target_gear = 2'd1;
    wait_req(5, "edge_req_start");
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!clutch_req) break;
      cnt++;
    end
    check("edge_req_cycles", cnt, ACK_TIMEOUT + 1);
    watch(20);
    check("edge_no_fault", w_fault_hi, 0);
    check("edge_gear", int'(cur_gear), 1);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      tick();
      target_gear  = 2'($urandom);
      target_valid = ($urandom_range(0, 3) != 0);
      clear_fault  = ($urandom_range(0, 15) == 0);
      rst          = ($urandom_range(0, 499) != 0);
      if (i % 20 == 0) begin
        rise_delay = $urandom_range(0, 9);
        fall_delay = $urandom_range(0, 9);
      end
    end
    tick();
    rst = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
